// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage next-PC selection, memory handshake and redirect buffering.
// Define PC_SEQUENCER_TRAP_EN to honour trap_in and turn misaligned branches into traps.
module pc_sequencer #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = 'h100
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pc_cur_in,
  output logic             imem_req_out,
  input  logic             imem_ack_in,
  input  logic             hazard_stall_in,
  input  logic             branch_taken_in,
  input  logic [WIDTH-1:0] branch_target_in,
  input  logic             trap_in,
  output logic [WIDTH-1:0] pc_next_out,
  output logic             pc_stall_out,
  output logic             fetch_valid_out,
  output logic             flush_out,
  output logic             misaligned_out
);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
  state_t state, state_nxt;
  logic pend_v;
  logic [WIDTH-1:0] pend_pc;
  logic mis, trap_v, br_mis, redir, take;
  logic [WIDTH-1:0] tgt, seq;
  assign seq = pc_cur_in + WIDTH'(4);
  assign mis = branch_taken_in && (branch_target_in[1:0] != 2'b00);
`ifdef PC_SEQUENCER_TRAP_EN
  assign trap_v = trap_in || mis;
  assign br_mis = mis && !trap_in;
  assign tgt    = trap_v ? TRAP_VECTOR : branch_target_in;
`else
  logic unused_trap;
  assign unused_trap = ^{trap_in, TRAP_VECTOR};
  assign trap_v = 1'b0;
  assign br_mis = mis;
  assign tgt    = {branch_target_in[WIDTH-1:2], 2'b00};
`endif
  assign redir = trap_v || branch_taken_in;
  // a branch may not displace an already buffered redirect; a trap always may
  assign take = imem_ack_in || trap_v || !pend_v;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state <= BOOT;
    else state <= state_nxt;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else if (state == FETCH) begin
      if (imem_ack_in) pend_v <= 1'b0;
      else if (redir && take) begin
        pend_v  <= 1'b1;
        pend_pc <= tgt;
      end
    end
  always_comb begin
    state_nxt = state;
    if (state == BOOT) state_nxt = FETCH;
    else if (state == FETCH) state_nxt = (imem_ack_in && !redir && !pend_v && hazard_stall_in) ? HOLD : FETCH;
    else state_nxt = (redir || !hazard_stall_in) ? FETCH : HOLD;
  end
  always_comb begin
    imem_req_out    = 1'b0;
    pc_stall_out    = 1'b1;
    pc_next_out     = pc_cur_in;
    fetch_valid_out = 1'b0;
    flush_out       = 1'b0;
    misaligned_out  = 1'b0;
    if (state == BOOT) pc_next_out = RESET_VECTOR;
    else if (state == FETCH) begin
      imem_req_out   = 1'b1;
      misaligned_out = br_mis && take;
      if (!imem_ack_in) flush_out = redir && take;
      else if (redir || pend_v) begin
        pc_stall_out = 1'b0;
        pc_next_out  = redir ? tgt : pend_pc;
        flush_out    = 1'b1;
      end else begin
        fetch_valid_out = 1'b1;
        pc_stall_out    = hazard_stall_in;
        pc_next_out     = hazard_stall_in ? pc_cur_in : seq;
      end
    end else begin
      misaligned_out = br_mis;
      pc_stall_out   = !redir && hazard_stall_in;
      pc_next_out    = redir ? tgt : (hazard_stall_in ? pc_cur_in : seq);
      flush_out      = redir;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random fetch scenarios against a transaction-level model.
module tb_pc_sequencer;
  localparam logic [31:0] TV = 32'h100;
`ifdef PC_SEQUENCER_TRAP_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_cur = '0, br_tgt = '0, pc_next;
  logic ack = 0, hz = 0, br = 0, tr = 0;
  logic req, stall, valid, flush, mis;
  int total = 0, bad = 0;
  bit m_boot, m_hold;
  logic [31:0] pend_q[$];
  logic [31:0] pc_q;
  always #5 clk = ~clk;
  pc_sequencer dut (
    .clk_in(clk), .rst_in(rst), .pc_cur_in(pc_cur), .imem_req_out(req),
    .imem_ack_in(ack), .hazard_stall_in(hz), .branch_taken_in(br),
    .branch_target_in(br_tgt), .trap_in(tr), .pc_next_out(pc_next),
    .pc_stall_out(stall), .fetch_valid_out(valid), .flush_out(flush),
    .misaligned_out(mis)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ack = 1'b1; br = 1'b1; br_tgt = 32'h303; tr = 1'b1; hz = 1'b0;
    #1;
    chk("rst_req", 32'(req), 0);
    chk("rst_stall", 32'(stall), 1);
    chk("rst_next", pc_next, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_mis", 32'(mis), 0);
    m_boot = 1; m_hold = 0; pend_q.delete(); pc_q = '0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask
  task automatic step(input bit a, input bit h, input bit b, input logic [31:0] bt, input bit t);
    logic [31:0] dest, e_next;
    bit bm, is_trap, have, took, e_req, e_stall, e_valid, e_flush, e_mis, cmp_next;
    @(negedge clk);
    pc_cur = pc_q; ack = a; hz = h; br = b; br_tgt = bt; tr = t;
    #1;
    bm = b && (bt[1:0] != 2'b00);
    is_trap = TEN && (t || bm);
    have = is_trap || b;
    dest = is_trap ? TV : {bt[31:2], 2'b00};
    e_req = 0; e_stall = 1; e_next = pc_q; e_valid = 0; e_flush = 0; e_mis = 0; cmp_next = 0;
    if (m_boot) begin
      e_next = 32'h0; cmp_next = 1; m_boot = 0;
    end else if (m_hold) begin
      e_mis = bm && !(TEN && t);
      if (have) begin
        e_stall = 0; e_next = dest; e_flush = 1; m_hold = 0;
      end else if (!h) begin
        e_stall = 0; e_next = pc_q + 32'd4; m_hold = 0;
      end
    end else begin
      e_req = 1;
      took = a || is_trap || pend_q.size() == 0;
      e_mis = bm && !(TEN && t) && took;
      if (!a) begin
        if (have && took) begin
          e_flush = 1; pend_q = {dest};
        end
      end else if (have || pend_q.size() > 0) begin
        e_stall = 0; e_flush = 1;
        e_next = have ? dest : pend_q[0];
        pend_q.delete();
      end else begin
        e_valid = 1;
        if (h) m_hold = 1;
        else begin
          e_stall = 0; e_next = pc_q + 32'd4;
        end
      end
    end
    if (!e_stall) cmp_next = 1;
    chk("req", 32'(req), 32'(e_req));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("misaligned", 32'(mis), 32'(e_mis));
    if (cmp_next) chk("pc_next", pc_next, e_next);
    if (!e_stall) pc_q = e_next;
  endtask
  initial begin
    logic [31:0] t;
    do_reset();
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    pc_q = 32'h10;
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    pc_q = 32'h20;
    step(0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    pc_q = 32'h40;
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h302, 0);
    pc_q = 32'hFFFF_FFFC;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h500, 0);
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h604, 0);
    step(1, 0, 0, 0, 0);
    repeat (1500) begin
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15, t, $urandom_range(0, 99) < 8);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that drives the `stall_in`/`pc_in` pair of the program-counter register and handshakes with instruction memory. It selects the next PC among sequential, branch/jump redirect and trap vector, and holds the PC for memory wait states and decode hazards. Redirects arriving while a fetch is outstanding are buffered. The wrong-path instruction is then discarded. Sits between the PC register, instruction memory port and IF/ID pipeline register.

## Interface
- WIDTH, 32, PC/address width
- RESET_VECTOR, 0, PC value presented during reset (matches PC register reset value)
- TRAP_VECTOR, 32'h0000_0100, trap handler address
- clk_in  input  1  clock
- rst_in  input  1  reset; asynchronous, active-low
- pc_cur_in  input  WIDTH  current PC from PC register output
- imem_req_out  output  1  fetch request to instruction memory at pc_cur_in
- imem_ack_in  input  1  instruction memory data valid this cycle
- hazard_stall_in  input  1  decode cannot accept an instruction (load-use etc.)
- branch_taken_in  input  1  redirect request from execute
- branch_target_in  input  WIDTH  redirect address
- trap_in  input  1  trap request (see Configuration)
- pc_next_out  output  WIDTH  to PC register `pc_in`
- pc_stall_out  output  1  to PC register `stall_in`; 1 = hold
- fetch_valid_out  output  1  fetched instruction is on-path; load IF/ID
- flush_out  output  1  invalidate IF/ID this cycle
- misaligned_out  output  1  one-cycle pulse: redirect target bits [1:0] != 0

## Operation
- States: BOOT, FETCH, HOLD. Plus pending-redirect register `pend_v`/`pend_pc`.
- Reset (async): state=BOOT, pend_v=0. Outputs: imem_req_out=0, pc_stall_out=1, pc_next_out=RESET_VECTOR, fetch_valid_out=0, flush_out=0, misaligned_out=0.
- BOOT: one cycle, no request, PC held; → FETCH.
- Redirect source this cycle, by priority: trap (TRAP_VECTOR) > branch (branch_target_in). Seq = pc_cur_in + 4, mod 2^WIDTH, so it wraps at all-ones.
- FETCH: imem_req_out=1.
  - No ack, no redirect: pc_stall_out=1.
  - No ack, redirect: capture into pend (trap overwrites a pending branch; a branch never overwrites pend_v=1); pc_stall_out=1.
  - Ack, redirect this cycle or pend_v: instruction discarded (fetch_valid_out=0, flush_out=1). PC loads the redirect target; a current redirect beats pend. pend_v cleared. Stay FETCH.
  - Ack, no redirect, hazard_stall_in=0: fetch_valid_out=1, PC loads seq.
  - Ack, no redirect, hazard_stall_in=1: fetch_valid_out=1, PC held, → HOLD.
- HOLD: imem_req_out=0, pc_stall_out=1.
  - Redirect: PC loads target, flush_out=1, → FETCH.
  - Else, hazard_stall_in falls: PC loads seq, → FETCH.
- flush_out also asserts in FETCH on the cycle a redirect is captured into pend.
- misaligned_out pulses on any accepted branch_taken_in whose target has bits [1:0] != 0.

## Timing
- State and pend update on posedge clk_in. pc_stall_out, pc_next_out, fetch_valid_out, flush_out and imem_req_out are combinational from state, pend and inputs.
- pc_cur_in changes at the negedge after the PC register's posedge load.
  - pc_next_out must settle within the following half cycle.
  - Memory samples the address for imem_req_out from the negedge.
- Zero-wait memory (ack every FETCH cycle, no stall): one instruction per cycle, PC +4 per posedge.
- Redirect penalty: target PC loaded at the posedge ending the ack cycle. First on-path instruction is no earlier than the next ack.
- Reset mid-fetch discards the outstanding request and the pend register. The first request after release follows the BOOT cycle.

## Configuration
- PC_SEQUENCER_TRAP_EN defined:
  - trap_in is honoured with highest priority.
  - A misaligned branch target is converted to a trap: PC loads TRAP_VECTOR, misaligned_out pulses.
- Undefined:
  - trap_in is ignored and TRAP_VECTOR is unused.
  - Misaligned branch targets are loaded with bits [1:0] forced to 0; misaligned_out still pulses.

## Test plan
- Reset release with pc_cur_in=0, ack always 1 → BOOT cycle with no request. Then pc_next_out=4, 8, 12 on consecutive cycles, fetch_valid_out=1 each cycle.
- Ack delayed 3 cycles at PC 0x10 → pc_stall_out=1 and imem_req_out=1 for 3 cycles. On ack, fetch_valid_out=1 and pc_next_out=0x14.
- Branch to 0x200 two cycles before ack at PC 0x20 → flush_out=1 on the capture cycle. On ack, fetch_valid_out=0, flush_out=1, PC loads 0x200, pend cleared.
- Ack with hazard_stall_in=1 for 2 cycles at PC 0x40 → HOLD, no request. PC held at 0x40, then 0x44 loaded when the stall drops.
- Branch to 0x302 (TRAP_EN defined) → misaligned_out pulse, PC loads 0x100. With TRAP_EN undefined → PC loads 0x300.
- pc_cur_in=0xFFFF_FFFC, ack → pc_next_out=0x0000_0000. Assert rst_in low mid-wait → outputs at reset values immediately, pend cleared.
